// File: rtl/route_cntrl_pkg.sv
// route_cntrl_pkg: shared opcodes, FSM states and width defaults
// for the multi-waypoint route controller.
package route_cntrl_pkg;

  localparam int ID_W_DEF = 6;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_GO     = 2'b01;
  localparam logic [1:0] OP_APPEND = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_MOVING = 1'b1;

endpackage

// File: rtl/dest_fifo.sv
// dest_fifo: circular waypoint queue with push, pop and flush.
// A flush with a concurrent push leaves exactly the pushed entry.
module dest_fifo
  import route_cntrl_pkg::*;
#(
  parameter  int W     = 6,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  din_i,
  output logic [W-1:0]  head_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] waddr;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr, rd;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rptr_q];

  assign wr    = push_i & (flush_i | ~full_o);
  assign rd    = pop_i & ~empty_o & ~flush_i;
  assign waddr = flush_i ? '0 : wptr_q;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      rptr_d = '0;
      wptr_d = AW'(wr);
      cnt_d  = (AW+1)'(wr);
    end else begin
      if (wr) wptr_d = wptr_q + 1'b1;
      if (rd) rptr_d = rptr_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      if (wr) mem_q[waddr] <= din_i;
    end
  end

endmodule

// File: rtl/route_cntrl.sv
// route_cntrl: decodes route commands, tracks waypoints, gates motion.
// Piezo drive while blocked is built only with ROUTE_CNTRL_BUZZ_EN.
module route_cntrl
  import route_cntrl_pkg::*;
#(
  parameter  int ID_W     = ID_W_DEF,
  parameter  int DEPTH    = 4,
  parameter  int BUZZ_DIV = 12500,
  localparam int CMD_W    = ID_W + 2,
  localparam int CW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CMD_W-1:0] cmd,
  input  logic             cmd_rdy,
  output logic             clr_cmd_rdy,
  input  logic [CMD_W-1:0] ID,
  input  logic             ID_vld,
  output logic             clr_ID_vld,
  input  logic             OK2Move,
  output logic             in_transit,
  output logic             go,
  output logic [ID_W-1:0]  dest_ID,
  output logic [CW:0]      route_cnt,
  output logic             route_done,
  output logic             cmd_err,
  output logic             buzz,
  output logic             buzz_n
);

  logic       state_q, state_d;
  logic       clr_cmd_q, clr_id_q;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       push, pop, flush, full, empty;
  logic       cmd_take, id_take, id_hit;
  logic [1:0] op;
  logic       unused_id;

  assign op        = cmd[CMD_W-1:CMD_W-2];
  assign unused_id = ^ID[CMD_W-1:ID_W] ^ empty;

  // A command always beats a station ID on the same edge.
  assign cmd_take = cmd_rdy & ~clr_cmd_q;
  assign id_take  = ID_vld & ~clr_id_q & ~cmd_take;
  assign id_hit   = id_take & (state_q == ST_MOVING)
                  & (ID[ID_W-1:0] == dest_ID);

  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    state_d = state_q;
    err_d   = 1'b0;
    done_d  = 1'b0;
    unique case (1'b1)
      cmd_take & (op == OP_STOP): begin
        flush   = 1'b1;
        state_d = ST_IDLE;
      end
      cmd_take & (op == OP_GO): begin
        flush   = 1'b1;
        push    = 1'b1;
        state_d = ST_MOVING;
      end
      cmd_take & (op == OP_APPEND): begin
        if (full) err_d = 1'b1;
        else      push  = 1'b1;
        state_d = ST_MOVING;
      end
      cmd_take & (op == OP_RSVD): begin
        err_d = 1'b1;
      end
      id_hit: begin
        pop = 1'b1;
        if (route_cnt == (CW+1)'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_cmd_q <= 1'b0;
      clr_id_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cmd_q <= cmd_take;
      clr_id_q  <= id_take;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  dest_fifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (cmd[ID_W-1:0]),
    .head_o  (dest_ID),
    .count_o (route_cnt),
    .full_o  (full),
    .empty_o (empty)
  );

  assign clr_cmd_rdy = clr_cmd_q;
  assign clr_ID_vld  = clr_id_q;
  assign route_done  = done_q;
  assign cmd_err     = err_q;
  assign in_transit  = (state_q == ST_MOVING);
  assign go          = in_transit & OK2Move;

`ifdef ROUTE_CNTRL_BUZZ_EN
  localparam int BW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          buzz_q, buzz_d;
  logic          blocked;

  assign blocked = in_transit & ~OK2Move;

  always_comb begin
    bcnt_d = '0;
    buzz_d = 1'b0;
    if (blocked) begin
      buzz_d = buzz_q;
      if (bcnt_q == BW'(BUZZ_DIV - 1)) begin
        buzz_d = ~buzz_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q <= '0;
      buzz_q <= 1'b0;
    end else begin
      bcnt_q <= bcnt_d;
      buzz_q <= buzz_d;
    end
  end

  assign buzz   = buzz_q;
  assign buzz_n = ~buzz_q;
`else
  logic unused_buzz;
  assign unused_buzz = (BUZZ_DIV != 0);
  assign buzz        = 1'b0;
  assign buzz_n      = 1'b1;
`endif

endmodule

// File: doc/route_cntrl.md
Name: route_cntrl

Overview:
Parametrised successor to the follower's single-destination command controller. Decodes commands from the command receiver into a multi-waypoint route held in a small destination queue. Compares incoming station IDs against the current waypoint and gates motion with OK2Move. Drives go and in_transit to the balance/motion path, and the piezo buzzer outputs while blocked in transit.

Parameters:
ID_W, 6, destination/station ID width; command width CMD_W = ID_W+2 (opcode in top 2 bits)
DEPTH, 4, waypoint queue depth (power of 2, >=2)
BUZZ_DIV, 12500, clk cycles per buzz half-period

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd  in  CMD_W  command word: [CMD_W-1:CMD_W-2] opcode, [ID_W-1:0] destination
cmd_rdy  in  1  command valid, held by source until cleared
clr_cmd_rdy  out  1  one-cycle pulse: command consumed
ID  in  CMD_W  station ID; only [ID_W-1:0] compared
ID_vld  in  1  station ID valid, held until cleared
clr_ID_vld  out  1  one-cycle pulse: ID consumed
OK2Move  in  1  path clear
in_transit  out  1  route active
go  out  1  in_transit & OK2Move (combinational)
dest_ID  out  ID_W  current waypoint (queue head), 0 when idle
route_cnt  out  $clog2(DEPTH)+1  waypoints queued
route_done  out  1  one-cycle pulse: final waypoint reached
cmd_err  out  1  one-cycle pulse: APPEND while full, or reserved opcode
buzz, buzz_n  out  1  piezo drive, complementary

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE, queue empty, in_transit=0, route_cnt=0, dest_ID=0, all pulses 0, buzz=0, buzz_n=1. Reset mid-route abandons the route; any pending cmd_rdy/ID_vld is evaluated afresh after release.
- States: IDLE, MOVING. in_transit = (state==MOVING), registered.
- Command consumed on an edge where cmd_rdy=1 and clr_cmd_rdy=0. clr_cmd_rdy pulses the following cycle. Its high cycle blocks re-consumption of a still-asserted cmd_rdy.
- Opcodes:
  - 00 STOP: flush queue, go to IDLE, no route_done.
  - 01 GO: flush, load cmd dest as sole waypoint, go to MOVING.
  - 10 APPEND: enqueue at tail; from IDLE also go to MOVING. If full, drop and pulse cmd_err.
  - 11 reserved: ignored, cmd_err pulse, clr_cmd_rdy still pulses.
- ID consumed on an edge where ID_vld=1 and clr_ID_vld=0, unless a command is consumed the same edge. clr_ID_vld pulses the next cycle.
  - In MOVING, if ID[ID_W-1:0]==dest_ID, pop head. If the queue becomes empty: go to IDLE and pulse route_done, registered, coincident with in_transit falling.
  - Mismatch: consumed, no state change.
  - In IDLE: consumed, ignored.
- Simultaneous cmd_rdy and ID_vld: the command wins. ID_vld stays pending and is compared next cycle against the new head, or ignored if the command left the block IDLE.
- Queue: circular, DEPTH entries. Pointers wrap mod DEPTH. route_cnt counts 0..DEPTH. A flush resets both pointers.
- Latency: command to in_transit/dest_ID is 1 cycle; ID match to dest_ID advance is 1 cycle.

Optional Feature:
ROUTE_CNTRL_BUZZ_EN:
- Defined: a counter runs while in_transit & ~OK2Move and toggles buzz every BUZZ_DIV cycles, starting from buzz=0. buzz_n = ~buzz. When the condition is false, the counter clears, buzz=0, buzz_n=1.
- Undefined: no counter; buzz tied 0, buzz_n tied 1.

Decomposition:
- Package route_cntrl_pkg: opcode constants (OP_STOP, OP_GO, OP_APPEND, OP_RSVD), state enum, ID_W default.
- Sub-module dest_fifo: parametrised circular queue with push, pop, flush, head, count, full, empty.

Test Plan (ID_W=6, DEPTH=4, BUZZ_DIV=4):
1. Reset test: rst=1 for 2 cycles with cmd_rdy=1 -> in_transit=0, go=0, route_cnt=0, buzz=0, buzz_n=1, clr_cmd_rdy=0. After release, cmd is consumed.
2. GO and arrival: cmd=8'h49 (GO to 0x09) with cmd_rdy held -> one clr_cmd_rdy pulse; next cycle in_transit=1, dest_ID=0x09, go=1 with OK2Move=1. ID=8'h0A with ID_vld -> clr_ID_vld pulse, still MOVING. ID=8'h09 -> in_transit=0, route_done pulse.
3. APPEND fill/overflow: from IDLE append 0x81,0x82,0x83,0x84 -> route_cnt=4, dest_ID=0x01. Append 0x85 -> cmd_err pulse, route_cnt stays 4. IDs 0x01..0x04 in turn -> dest_ID steps through them; route_done on the 4th only.
4. Blocked buzz: MOVING with OK2Move=0 -> go=0, buzz toggles every 4 cycles, buzz_n=~buzz. OK2Move=1 -> buzz=0, buzz_n=1 next cycle. With ROUTE_CNTRL_BUZZ_EN undefined, buzz stays 0.
5. Collision: MOVING to 0x09; cmd=8'h00 (STOP) and ID=8'h09 asserted the same edge -> STOP wins, IDLE, no route_done. ID is cleared a cycle later with no effect.
6. Reserved/reset mid-route: cmd=8'hC5 -> cmd_err, state unchanged. rst=1 during a 3-entry route -> IDLE, route_cnt=0 next cycle.
